// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter serializing four requesters onto one slow memory port
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  req_rnotw,
  input  logic [15:0] req_addr0,
  input  logic [15:0] req_addr1,
  input  logic [15:0] req_addr2,
  input  logic [15:0] req_addr3,
  input  logic [15:0] req_wdata0,
  input  logic [15:0] req_wdata1,
  input  logic [15:0] req_wdata2,
  input  logic [15:0] req_wdata3,
  output logic [3:0]  ack,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_strobe,
  output logic        mem_rnotw,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_mfc,
  input  logic [15:0] mem_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d, last_q, last_d, win;
  logic          rnotw_q, rnotw_d, err_q, err_d;
  logic [15:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // search upward from last_q+1; the last grant itself has the lowest priority
  always_comb begin
    win = last_q;
    for (int k = 4; k >= 1; k--)
      if (req[last_q + 2'(k)]) win = last_q + 2'(k);
  end
  // next-state: latch the winner in IDLE, one strobe in ISSUE, wait for mfc or timeout, one ack
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rnotw_d = rnotw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = ISSUE;
        grant_d = win;
        rnotw_d = req_rnotw[win];
        addr_d  = win == 2'd0 ? req_addr0 : win == 2'd1 ? req_addr1 : win == 2'd2 ? req_addr2 : req_addr3;
        wdata_d = win == 2'd0 ? req_wdata0 : win == 2'd1 ? req_wdata1 : win == 2'd2 ? req_wdata2 : req_wdata3;
      end
      ISSUE: begin
        state_d = rnotw_q ? WAIT : RESP;
        cnt_d   = '0;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      WAIT: if (mem_mfc) begin
        state_d = RESP;
        rdata_d = mem_rdata;
        err_d   = 1'b0;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = RESP;
        rdata_d = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        last_d  = grant_q;
      end
    endcase
  end
  // state register; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'd3;
      rnotw_q <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rnotw_q <= rnotw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy       = state_q != IDLE;
  assign mem_strobe = state_q == ISSUE;
  assign mem_rnotw  = state_q == ISSUE ? rnotw_q : 1'b1;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign ack        = state_q == RESP ? 4'b0001 << grant_q : 4'b0000;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, corner sequences and random traffic against a reference model
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0, req_rnotw = 4'b0;
  logic [15:0] a [4];
  logic [15:0] wd [4];
  logic [3:0]  ack;
  logic [15:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        resp_err, busy, mem_strobe, mem_rnotw, mem_mfc;
  logic        sm_mfc, stray = 1'b0, mfc_en = 1'b1;
  logic [15:0] sm_rd = 16'h0;
  logic [15:0] sm [256];
  logic [15:0] ref_mem [256];
  int          mfc_delay = 4, sm_cnt, ref_last = 3, errors = 0, checks = 0;

  always #5 clk = ~clk;

  assign mem_mfc   = sm_mfc | stray;
  assign mem_rdata = sm_rd;

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rnotw(req_rnotw),
    .req_addr0(a[0]), .req_addr1(a[1]), .req_addr2(a[2]), .req_addr3(a[3]),
    .req_wdata0(wd[0]), .req_wdata1(wd[1]), .req_wdata2(wd[2]), .req_wdata3(wd[3]),
    .ack(ack), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .mem_strobe(mem_strobe), .mem_rnotw(mem_rnotw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mfc(mem_mfc), .mem_rdata(mem_rdata)
  );

  function automatic logic [15:0] init_val(input int i);
    return i == 16 ? 16'h1234 : 16'(i * 257) ^ 16'h5A5A;
  endfunction

  // slow memory: writes land at the strobe, reads pulse mfc mfc_delay edges after the strobe
  always @(posedge clk or posedge reset)
    if (reset) begin
      sm_cnt <= 0;
      sm_mfc <= 1'b0;
      for (int i = 0; i < 256; i++) sm[i] <= init_val(i);
    end else begin
      sm_mfc <= 1'b0;
      if (mem_strobe && !mem_rnotw) sm[mem_addr[7:0]] <= mem_wdata;
      else if (mem_strobe) begin
        sm_cnt <= mfc_delay;
        sm_rd  <= sm[mem_addr[7:0]];
      end else if (sm_cnt == 1) begin
        sm_cnt <= 0;
        sm_mfc <= mfc_en;
      end else if (sm_cnt > 1) sm_cnt <= sm_cnt - 1;
    end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic int ref_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
    return 0;
  endfunction

  // wait for the next ack and check it against the reference model; drops the winner's req
  task automatic serve(input string nm, input int exp_lat, output logic [3:0] g_ack,
                       output logic [15:0] g_rd, output logic g_err);
    int w, cyc, strobes, waits, bad_fields, bad_wait;
    logic rn, exp_err, last_mfc;
    logic [15:0] exp_rd;
    w = ref_pick(req, ref_last);
    rn = req_rnotw[w];
    exp_err = rn && !mfc_en;
    exp_rd = (rn && mfc_en) ? ref_mem[a[w][7:0]] : 16'h0;
    cyc = 0; strobes = 0; waits = 0; bad_fields = 0; bad_wait = 0; last_mfc = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (mem_strobe) begin
        strobes++;
        if (mem_rnotw !== rn || mem_addr !== a[w] || (!rn && mem_wdata !== wd[w])) bad_fields++;
      end
      if (busy && !mem_strobe && ack == 4'b0) begin
        waits++;
        if (mem_rnotw !== 1'b1) bad_wait++;
      end
      if (ack == 4'b0) last_mfc = mem_mfc;
    end while (ack == 4'b0 && cyc < 100);
    chk({nm, "_ack"}, 32'(ack), 32'(4'b0001 << w));
    chk({nm, "_rdata"}, 32'(resp_rdata), 32'(exp_rd));
    chk({nm, "_err"}, 32'(resp_err), 32'(exp_err));
    chk({nm, "_strobes"}, 32'(strobes), 32'd1);
    chk({nm, "_strobe_fields"}, 32'(bad_fields), 32'd0);
    chk({nm, "_wait_rnotw"}, 32'(bad_wait), 32'd0);
    chk({nm, "_wait_cycles"}, 32'(waits), 32'(rn ? (mfc_en ? mfc_delay + 1 : 16) : 0));
    if (rn && mfc_en) chk({nm, "_mfc_before_ack"}, 32'(last_mfc), 32'd1);
    if (exp_lat > 0) chk({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
    g_ack = ack; g_rd = resp_rdata; g_err = resp_err;
    if (!rn) ref_mem[a[w][7:0]] = wd[w];
    ref_last = w;
    req[w] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b0; stray = 1'b0; mfc_en = 1'b1; mfc_delay = 4;
    @(negedge clk); @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'(mem_strobe), 32'd0);
    chk("rst_rnotw", 32'(mem_rnotw), 32'd1);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    reset = 1'b0; ref_last = 3;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    @(negedge clk);
  endtask

  typedef struct {
    int idx; logic rn; logic [15:0] ad; logic [15:0] wdv; int lat;
    logic [3:0] eack; logic [15:0] erd; logic eerr;
  } vec_t;
  vec_t tv [7];

  initial begin
    logic [3:0] g_ack;
    logic [15:0] g_rd;
    logic g_err;
    int seen;
    logic [3:0] order [5];
    for (int i = 0; i < 4; i++) begin a[i] = 16'h0; wd[i] = 16'h0; end
    tv[0] = '{0, 1'b1, 16'h0010, 16'h0000, 0, 4'b0001, 16'h1234, 1'b0};
    tv[1] = '{2, 1'b0, 16'h0020, 16'hBEEF, 2, 4'b0100, 16'h0000, 1'b0};
    tv[2] = '{2, 1'b1, 16'h0020, 16'h0000, 0, 4'b0100, 16'hBEEF, 1'b0};
    tv[3] = '{3, 1'b0, 16'h0030, 16'h5A5A, 2, 4'b1000, 16'h0000, 1'b0};
    tv[4] = '{1, 1'b1, 16'h0030, 16'h0000, 0, 4'b0010, 16'h5A5A, 1'b0};
    tv[5] = '{0, 1'b0, 16'h1234, 16'h0001, 2, 4'b0001, 16'h0000, 1'b0};
    tv[6] = '{3, 1'b1, 16'h1234, 16'h0000, 0, 4'b1000, 16'h0001, 1'b0};
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b1000; order[4] = 4'b0001;
    do_reset();
    foreach (tv[i]) begin
      @(negedge clk);
      req_rnotw[tv[i].idx] = tv[i].rn; a[tv[i].idx] = tv[i].ad; wd[tv[i].idx] = tv[i].wdv;
      req = 4'b0001 << tv[i].idx;
      serve("vec", tv[i].lat, g_ack, g_rd, g_err);
      chk("vec_tbl_ack", 32'(g_ack), 32'(tv[i].eack));
      chk("vec_tbl_rdata", 32'(g_rd), 32'(tv[i].erd));
      chk("vec_tbl_err", 32'(g_err), 32'(tv[i].eerr));
    end
    // timeout: no mfc ever arrives
    @(negedge clk);
    mfc_en = 1'b0; req_rnotw[1] = 1'b1; a[1] = 16'h0044; req = 4'b0010;
    serve("timeout", 18, g_ack, g_rd, g_err);
    chk("timeout_tbl_err", 32'(g_err), 32'd1);
    chk("timeout_tbl_rdata", 32'(g_rd), 32'd0);
    @(negedge clk);
    chk("timeout_idle", 32'(busy), 32'd0);
    // mfc arrives on the same edge the timeout would fire: data wins
    mfc_en = 1'b1; mfc_delay = 15; req_rnotw[2] = 1'b1; a[2] = 16'h0010; req = 4'b0100;
    serve("coincide", 18, g_ack, g_rd, g_err);
    chk("coincide_tbl_err", 32'(g_err), 32'd0);
    chk("coincide_tbl_rdata", 32'(g_rd), 32'h1234);
    // stray mfc while idle
    mfc_delay = 4;
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    chk("stray_ack", 32'(ack), 32'd0);
    chk("stray_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("stray_ack2", 32'(ack), 32'd0);
    req_rnotw[3] = 1'b0; a[3] = 16'h0050; wd[3] = 16'hCAFE; req = 4'b1000;
    serve("stray_wr", 2, g_ack, g_rd, g_err);
    // contention from reset: all four keep requesting
    do_reset();
    for (int i = 0; i < 4; i++) begin req_rnotw[i] = 1'b1; a[i] = 16'(16'h0060 + i); end
    mfc_delay = 2; req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      serve("contend", 0, g_ack, g_rd, g_err);
      chk("contend_order", 32'(g_ack), 32'(order[n]));
      req = req | g_ack;
    end
    req = 4'b0;
    // reset two cycles into WAIT
    @(negedge clk);
    mfc_delay = 8; req_rnotw[0] = 1'b1; a[0] = 16'h0077; req = 4'b0001;
    @(negedge clk); @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_strobe", 32'(mem_strobe), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_rnotw", 32'(mem_rnotw), 32'd1);
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    req = 4'b0;
    @(negedge clk);
    reset = 1'b0; ref_last = 3;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    seen = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (ack != 4'b0) seen++; end
    chk("midrst_no_ack", 32'(seen), 32'd0);
    req_rnotw[1] = 1'b1; a[1] = 16'h0010; mfc_delay = 4; req = 4'b0010;
    serve("after_rst", 0, g_ack, g_rd, g_err);
    chk("after_rst_tbl_ack", 32'(g_ack), 32'b0010);
    chk("after_rst_tbl_rdata", 32'(g_rd), 32'h1234);
    // random traffic against the reference model
    for (int it = 0; it < 150; it++) begin
      for (int i = 0; i < 4; i++)
        if (!req[i] && $urandom_range(0, 2) != 0) begin
          req_rnotw[i] = 1'($urandom_range(0, 1));
          a[i] = 16'($urandom);
          wd[i] = 16'($urandom);
          req[i] = 1'b1;
        end
      if (req == 4'b0) req[$urandom_range(0, 3)] = 1'b1;
      mfc_delay = $urandom_range(1, 15);
      mfc_en = $urandom_range(0, 7) != 0;
      serve("rand", 0, g_ack, g_rd, g_err);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
